serial_sub6: RTL and testbench
==============================

SERIAL_SUB6 -- requirements
Module: serial_sub6

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request: capture a,b and begin a subtraction.
REQ-005 SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  single-cycle pulse: diff is valid.
REQ-009 SHALL have port diff  output  WIDTH+1  [WIDTH-1:0] = (a-b) mod 2^WIDTH; [WIDTH] = final borrow (1 iff a<b unsigned).

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL capture a and b into shift registers, clear the borrow and the bit counter, and enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL subtract one bit pair, LSB first, with the registered borrow, and shift the difference bit into the result register.
REQ-013 SHALL remain in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-014 Latency: start sampled at edge T SHALL give busy=1 for cycles T+1..T+WIDTH, and done=1 with diff valid at T+WIDTH+1.
REQ-015 done SHALL be high only in DONE; DONE with start=0 SHALL return to IDLE on the next edge.
REQ-016 diff SHALL update only on the SHIFT->DONE edge and SHALL hold until the next completion.
REQ-017 start while in SHIFT SHALL be ignored, and a/b changes during SHIFT SHALL have no effect.
REQ-018 start in the DONE cycle SHALL be accepted (back-to-back operation), with no idle cycle between operations.
REQ-019 busy and done SHALL never be high in the same cycle.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, borrow=0 and counter=0.
REQ-021 Reset mid-SHIFT SHALL discard the operation; no done SHALL follow reset release without a new start.

Configuration
REQ-022 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output ovf (1 bit): signed two's-complement overflow of a-b, valid and held with diff, reset 0.
REQ-023 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the captured operands.
REQ-024 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and constant DEFAULT_WIDTH = 6.
REQ-026 One sub-module SHALL be used: full_subtractor (ports a, b, bin, d, bout; d = a^b^bin, bout = (~a&b)|(~(a^b)&bin)), instantiated once in the bit-serial datapath.

Verification
REQ-027 WIDTH=6, a=13, b=5, start at T -> busy at T+1..T+6; done at T+7 with diff=7'h08.
REQ-028 a=5, b=13 -> diff=7'h78 (low bits 56, borrow 1); with SERIAL_SUB_OVF_EN, ovf=0.
REQ-029 a=31, b=32 (signed +31 - (-32)) with SERIAL_SUB_OVF_EN -> diff=7'h7F and ovf=1; a=63, b=63 -> diff=0 and ovf=0.
REQ-030 start pulsed at T+3 during a busy operation -> ignored; a single done at T+7; start held high through DONE -> a second operation starts with busy at T+8.
REQ-031 rst_n low at T+4 mid-operation -> busy, done and diff are 0 at once; no done follows until a new start.

Source files
------------

// File: rtl/serial_sub6_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub6_if.sv
// Request/result bundle for serial_sub6; ovf present only with SERIAL_SUB_OVF_EN.
interface serial_sub6_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  modport master (output start, a, b, input busy, done, diff, ovf);
  modport slave  (input start, a, b, output busy, done, diff, ovf);
`else
  modport master (output start, a, b, input busy, done, diff);
  modport slave  (input start, a, b, output busy, done, diff);
`endif

endinterface

// File: rtl/serial_sub6_fs.sv
// One-bit full subtractor used by the serial datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub6.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by macro SERIAL_SUB_OVF_EN.
module serial_sub6
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub6_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_load     = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = WIDTH'({w_d, r_res} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == SHIFT);
    bus.done = (r_state == DONE);
    bus.diff = r_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_cnt    <= r_cnt + CW'(1);
      r_borrow <= w_bout;
      if (w_last) r_diff <= {w_bout, w_res_next};
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb;
  logic r_bmsb;
  logic r_ovf;

  // On the last bit w_d is the result MSB, so overflow resolves with diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_amsb <= bus.a[WIDTH-1];
      r_bmsb <= bus.b[WIDTH-1];
    end else if (r_state == SHIFT && w_last) begin
      r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub6.sv
// Directed self-checking bench for serial_sub6 (WIDTH=6).
module tb_serial_sub6;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  serial_sub6_if #(.WIDTH(6)) u_if ();

  serial_sub6 #(.WIDTH(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one start and checks the full latency profile.
  task automatic run_op(input string tag, input logic [5:0] ia, input logic [5:0] ib,
                        input logic [6:0] ediff, input logic eovf);
    u_if.start = 1'b1;
    u_if.a     = ia;
    u_if.b     = ib;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(u_if.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(u_if.done), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(u_if.done), 32'd1);
    chk({tag, "_notbusy"}, 32'(u_if.busy), 32'd0);
    chk({tag, "_diff"}, 32'(u_if.diff), 32'(ediff));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(u_if.ovf), 32'(eovf));
`else
    if (eovf === 1'bz) $display("note: unexpected ovf argument");
`endif
    @(negedge clk);
    chk({tag, "_idle"}, 32'({u_if.busy, u_if.done}), 32'd0);
    chk({tag, "_hold"}, 32'(u_if.diff), 32'(ediff));
  endtask

  initial begin
    logic seen;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    u_if.start = 1'b0;
    u_if.a     = '0;
    u_if.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_diff", 32'(u_if.diff), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("a13_b5",  6'd13, 6'd5,  7'h08, 1'b0);
    run_op("a5_b13",  6'd5,  6'd13, 7'h78, 1'b0);
    run_op("a31_b32", 6'd31, 6'd32, 7'h7F, 1'b1);
    run_op("a63_b63", 6'd63, 6'd63, 7'h00, 1'b0);
    run_op("a0_b1",   6'd0,  6'd1,  7'h7F, 1'b0);
    run_op("a32_b1",  6'd32, 6'd1,  7'h1F, 1'b1);

    // Mid-operation start and operand changes ignored; start in DONE chains.
    u_if.start = 1'b1;
    u_if.a     = 6'd13;
    u_if.b     = 6'd5;
    @(posedge clk);
    #1 begin
      u_if.start = 1'b0;
      u_if.a     = 6'd63;
      u_if.b     = 6'd1;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("b2b_busy1", 32'(u_if.busy), 32'd1);
      chk("b2b_nodone1", 32'(u_if.done), 32'd0);
      u_if.start = (k == 2);
    end
    @(negedge clk);
    chk("b2b_done1", 32'(u_if.done), 32'd1);
    chk("b2b_diff1", 32'(u_if.diff), 32'h08);
    u_if.start = 1'b1;
    u_if.a     = 6'd5;
    u_if.b     = 6'd13;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("b2b_busy2_start", 32'(u_if.busy), 32'd1);
    chk("b2b_nodone2_start", 32'(u_if.done), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk("b2b_busy2", 32'(u_if.busy), 32'd1);
      chk("b2b_hold1", 32'(u_if.diff), 32'h08);
    end
    @(negedge clk);
    chk("b2b_done2", 32'(u_if.done), 32'd1);
    chk("b2b_diff2", 32'(u_if.diff), 32'h78);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    u_if.start = 1'b1;
    u_if.a     = 6'd13;
    u_if.b     = 6'd5;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(u_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(u_if.busy), 32'd0);
    chk("mid_rst_done", 32'(u_if.done), 32'd0);
    chk("mid_rst_diff", 32'(u_if.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);

    run_op("post_rst", 6'd40, 6'd8, 7'h20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
